// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide engine for the EXE stage.
// Computes MULT/MULTU (signed/unsigned 32x32->64) and DIV/DIVU (restoring
// division, one quotient bit per cycle) and presents {hi,lo} on result.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          EXE holds a mul/div instruction (level)
//   op             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b   forwarded rs/rt operands, sampled only at acceptance
//   ex_hold        EXE held by another stall source
//   flush          irq/clr: kills the in-flight operation
//   stall          stall request to the EXE/MEM register and upstream
//   done           result valid (high only in the DONE state)
//   result         {hi,lo}: product, or {remainder, quotient}
//
// Handshake: an instruction is accepted when start=1 and flush=0 in IDLE.
// done stays high while ex_hold=1; the instruction leaves EXE on the first
// DONE cycle with ex_hold=0, and the unit is back in IDLE the cycle after.
// The internal signal "state" is the FSM observation point.
module muldiv_unit #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_ITER    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [7:0] MUL_LAST = 8'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
  localparam logic [7:0] DIV_LAST = 8'(DIV_ITER - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic        sgn_q;      // 1 for the signed ops (MULT, DIV)
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;      // dividend shifts out the top, quotient bits in
  logic [31:0] dvs_q;      // divisor magnitude
  logic        q_neg;
  logic        r_neg;
  logic [63:0] result_q;

  logic        accept;
  logic        mul_last;
  logic        div_last;

  // Low 64 bits of the sign/zero-extended 64x64 product are the exact
  // 32x32 product in both signed and unsigned interpretations.
  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  assign accept   = (state == S_IDLE) && start && !flush;
  assign mul_last = (state == S_MUL) && (cnt == MUL_LAST);
  assign div_last = (state == S_DIV) && (cnt == DIV_LAST);

  // One restoring-division step.
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] div_res;

  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    take    = !diff[32];
    rem_nx  = take ? diff[31:0] : rem_sh[31:0];
    quo_nx  = {quo_q[30:0], take};
    q_fix   = (sgn_q && q_neg) ? (~quo_nx + 32'd1) : quo_nx;
    r_fix   = (sgn_q && r_neg) ? (~rem_nx + 32'd1) : rem_nx;
    // Divide by zero: the iterations still run so latency is fixed.
    div_res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and outputs. flush wins over start and completion.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_next = op[1] ? S_DIV :
                                       ((MUL_LATENCY == 1) ? S_DONE : S_MUL);
        S_MUL:  if (mul_last) state_next = S_DONE;
        S_DIV:  if (div_last) state_next = S_DONE;
        S_DONE: if (!ex_hold) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
    stall = accept || (state == S_MUL) || (state == S_DIV);
    done  = (state == S_DONE);
  end

  // Datapath: operand latches, counter, division registers, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      sgn_q    <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= 64'd0;
    end else if (accept) begin
      cnt   <= 8'd0;
      sgn_q <= !op[0];
      a_q   <= src_a;
      b_q   <= src_b;
      rem_q <= 32'd0;
      quo_q <= (!op[0] && src_a[31]) ? (~src_a + 32'd1) : src_a;
      dvs_q <= (!op[0] && src_b[31]) ? (~src_b + 32'd1) : src_b;
      q_neg <= src_a[31] ^ src_b[31];
      r_neg <= src_a[31];
      if (!op[1] && (MUL_LATENCY == 1)) result_q <= mul64(!op[0], src_a, src_b);
    end else if ((state == S_MUL) && !flush) begin
      if (mul_last) result_q <= mul64(sgn_q, a_q, b_q);
      else          cnt <= cnt + 8'd1;
    end else if ((state == S_DIV) && !flush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt   <= cnt + 8'd1;
      if (div_last) result_q <= div_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Inputs are driven 1ns
// after the rising edge, outputs are compared on the falling edge against a
// cycle-countdown reference model computed with plain integer arithmetic.
module tb_muldiv_unit;

  localparam int MUL_L = 2;
  localparam int DIV_L = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        ex_hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.MUL_LATENCY(MUL_L), .DIV_ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .ex_hold(ex_hold), .flush(flush), .stall(stall),
    .done(done), .result(result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference result from the arithmetic definition of each op.
  function automatic logic [63:0] ref_fn(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'd0) return 64'(sa * sb);
    if (o == 2'd1) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      // 64-bit arithmetic: -2^31 / -1 = 2^31 truncates to 0x80000000.
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_retired = 0;
  int          m_left = 0;
  logic [63:0] m_pending = 64'd0;
  logic [63:0] m_result = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    int lat;
    m_retired = 0;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_result = 64'd0;
    end else if (flush) begin
      m_busy = 0; m_done = 0;
    end else if (m_done) begin
      if (!ex_hold) begin m_done = 0; m_retired = 1; end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_done = 1; m_result = m_pending; end
    end else if (start) begin
      m_pending = ref_fn(op, src_a, src_b);
      lat = op[1] ? DIV_L : MUL_L;
      if (lat == 1) begin m_done = 1; m_result = m_pending; end
      else begin m_busy = 1; m_left = lat - 1; end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("cyc_stall", 64'(stall), 64'(m_busy || (!m_done && start && !flush)));
    check("cyc_done", 64'(done), 64'(m_done));
    check("cyc_result", result, m_result);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
  endtask

  // Called at cycle 0 (1ns after the edge). Returns on the falling edge of
  // the first done cycle, or after a bounded number of cycles.
  task automatic wait_done(input string name, input int exp_lat, input logic [63:0] exp_res);
    int n;
    for (n = 0; n <= 60; n++) begin
      if (n > 0) begin src_a = $urandom; src_b = $urandom; end
      @(negedge clk);
      check({name, "_stall"}, 64'(stall), 64'(n < exp_lat));
      if (done) break;
      @(posedge clk); #1;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_result"}, result, exp_res);
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed values that pin the reference function.
    check("pin_mult", ref_fn(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    check("pin_multu", ref_fn(2'd1, 32'hFFFF_FFFD, 32'd5), 64'h0000_0004_FFFF_FFF1);
    check("pin_div_neg", ref_fn(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_div_ovf", ref_fn(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    // Directed operations with literal expectations.
    issue(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", MUL_L, 64'hFFFF_FFFF_FFFF_FFF1); finish_op();
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    wait_done("multu", MUL_L, 64'h0000_0004_FFFF_FFF1); finish_op();
    issue(2'd3, 32'd100, 32'd7);
    wait_done("divu", DIV_L, {32'd2, 32'd14}); finish_op();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", DIV_L, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); finish_op();
    issue(2'd2, 32'h1234_5678, 32'd0);
    wait_done("div_zero", DIV_L, {32'h1234_5678, 32'hFFFF_FFFF}); finish_op();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_L, {32'd0, 32'h8000_0000}); finish_op();

    // Flush at cycle 10 of a DIVU.
    issue(2'd3, 32'd1000, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_after_stall", 64'(stall), 64'd0);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (done) cnt++; end
    check("flush_no_done", 64'(cnt), 64'd0);
    check("flush_result_kept", result, {32'd0, 32'h8000_0000});
    @(posedge clk); #1;

    // flush together with start in IDLE: nothing is accepted.
    issue(2'd1, 32'd3, 32'd3);
    flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_start_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_done", 64'(done), 64'd0);
    check("flush_start_result", result, {32'd0, 32'h8000_0000});
    @(posedge clk); #1;

    // ex_hold for three cycles in DONE with start still high.
    issue(2'd0, 32'd6, 32'd7);
    wait_done("hold_mult", MUL_L, 64'd42);
    ex_hold = 1'b1;
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin ex_hold = 1'b0; op = 2'd0; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; end
      @(negedge clk);
      if (done) cnt++;
    end
    check("hold_done_cycles", 64'(cnt), 64'd4);
    @(posedge clk); #1;
    wait_done("after_hold_mult", MUL_L, 64'd1); finish_op();

    // Reset in the middle of a divide.
    issue(2'd3, 32'd1000, 32'd3);
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'd3, 32'd9, 32'd3);
    wait_done("divu_after_rst", DIV_L, {32'd0, 32'd3}); finish_op();

    // Randomized traffic: ex_hold, operand churn and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      if (flush) begin
        flush = 1'b0; start = 1'b0;
      end else if (!start || m_retired) begin
        if ($urandom_range(0, 2) != 0) issue(2'($urandom_range(0, 3)), rand_word(), rand_word());
        else start = 1'b0;
      end else if (m_busy) begin
        src_a = $urandom; src_b = $urandom;
      end
      ex_hold = ($urandom_range(0, 2) == 0);
      if (start && !flush) flush = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
